// File: rtl/tx_min_frame_pad.sv
// Pads outgoing Ethernet frames with zero bytes up to MIN_BYTES (FCS excluded) and
// normalizes tkeep ahead of the 64-to-8 TX serializer; one registered output slice.
module tx_min_frame_pad #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MIN_BYTES = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] app_axis_tdata,
  input  logic [KEEP_W-1:0] app_axis_tkeep,
  input  logic              app_axis_tvalid,
  input  logic              app_axis_tlast,
  input  logic              app_axis_tuser,
  output logic              app_axis_tready,
  output logic [DATA_W-1:0] tx_axis_tdata,
  output logic [KEEP_W-1:0] tx_axis_tkeep,
  output logic              tx_axis_tvalid,
  output logic              tx_axis_tuser,
  output logic              tx_axis_tlast,
  input  logic              tx_axis_tready,
  output logic              frame_padded
);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  localparam logic [7:0] MIN_B    = 8'(MIN_BYTES);
  localparam logic [7:0] BEAT_B   = 8'(KEEP_W);
  localparam logic [6:0] SAT_EDGE = 7'(127 - KEEP_W);
  localparam logic [6:0] BEAT_7   = 7'(KEEP_W);

  logic [0:0]        state;
  logic [6:0]        byte_cnt;
  logic [6:0]        remaining;
  logic              saved_user;
  logic              out_padded;

  logic              load_ok;
  logic              in_accept;
  logic [7:0]        n_bytes;
  logic              keep_run;
  logic              keep_err;
  logic [DATA_W-1:0] last_data;
  logic [7:0]        sum_bytes;
  logic              pad_last;
  logic [7:0]        need_bytes;

  function automatic logic [KEEP_W-1:0] low_mask(input logic [7:0] k);
    logic [KEEP_W-1:0] m;
    for (int i = 0; i < KEEP_W; i++) m[i] = (8'(i) < k);
    return m;
  endfunction

  assign load_ok         = !tx_axis_tvalid || tx_axis_tready;
  assign app_axis_tready = reset_n && (state == ST_PASS) && load_ok;
  assign in_accept       = app_axis_tvalid && app_axis_tready;
  assign frame_padded    = tx_axis_tvalid && tx_axis_tready && tx_axis_tlast && out_padded;

  // Last-beat analysis: contiguous byte count, zeroed tail and bytes still owed to reach MIN_BYTES.
  always_comb begin
    n_bytes  = 8'd0;
    keep_run = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep_run && app_axis_tkeep[i]) n_bytes = n_bytes + 8'd1;
      else keep_run = 1'b0;
    end
    keep_err = ~app_axis_tkeep[0];
    if (keep_err) n_bytes = 8'd1;

    last_data = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (8'(i) < n_bytes) last_data[8*i +: 8] = app_axis_tdata[8*i +: 8];
    end

    sum_bytes  = {1'b0, byte_cnt} + n_bytes;
    pad_last   = sum_bytes < MIN_B;
    need_bytes = pad_last ? (MIN_B - {1'b0, byte_cnt}) : n_bytes;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_PASS;
      byte_cnt       <= 7'd0;
      remaining      <= 7'd0;
      saved_user     <= 1'b0;
      out_padded     <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tuser  <= 1'b0;
    end else begin
      if (tx_axis_tvalid && tx_axis_tready) tx_axis_tvalid <= 1'b0;

      case (state)
        ST_PASS: begin
          if (in_accept) begin
            tx_axis_tvalid <= 1'b1;
            if (!app_axis_tlast) begin
              tx_axis_tdata <= app_axis_tdata;
              tx_axis_tkeep <= '1;
              tx_axis_tlast <= 1'b0;
              tx_axis_tuser <= 1'b0;
              out_padded    <= 1'b0;
              byte_cnt      <= (byte_cnt > SAT_EDGE) ? 7'd127 : byte_cnt + BEAT_7;
            end else if (need_bytes <= BEAT_B) begin
              tx_axis_tdata <= last_data;
              tx_axis_tkeep <= low_mask(need_bytes);
              tx_axis_tlast <= 1'b1;
              tx_axis_tuser <= app_axis_tuser | keep_err;
              out_padded    <= pad_last;
              byte_cnt      <= 7'd0;
            end else begin
              // The first beat already carries a full word; the rest is owed as zero beats.
              tx_axis_tdata <= last_data;
              tx_axis_tkeep <= '1;
              tx_axis_tlast <= 1'b0;
              tx_axis_tuser <= 1'b0;
              out_padded    <= 1'b0;
              saved_user    <= app_axis_tuser | keep_err;
              remaining     <= 7'(need_bytes - BEAT_B);
              state         <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (load_ok) begin
            tx_axis_tvalid <= 1'b1;
            tx_axis_tdata  <= '0;
            if (remaining <= BEAT_7) begin
              tx_axis_tkeep <= low_mask({1'b0, remaining});
              tx_axis_tlast <= 1'b1;
              tx_axis_tuser <= saved_user;
              out_padded    <= 1'b1;
              byte_cnt      <= 7'd0;
              state         <= ST_PASS;
            end else begin
              tx_axis_tkeep <= '1;
              tx_axis_tlast <= 1'b0;
              tx_axis_tuser <= 1'b0;
              out_padded    <= 1'b0;
              remaining     <= remaining - BEAT_7;
            end
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

endmodule
